// File: rtl/core_controller_axi_master_if.sv
// AXI4-Lite bus bundle between the core controller initiator and its
// register slave.
interface core_controller_axi_master_if #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 32
);
    logic [ADDR_W-1:0]   M_AXI_AWADDR;
    logic [2:0]          M_AXI_AWPROT;
    logic                M_AXI_AWVALID;
    logic                M_AXI_AWREADY;
    logic [DATA_W-1:0]   M_AXI_WDATA;
    logic [DATA_W/8-1:0] M_AXI_WSTRB;
    logic                M_AXI_WVALID;
    logic                M_AXI_WREADY;
    logic [1:0]          M_AXI_BRESP;
    logic                M_AXI_BVALID;
    logic                M_AXI_BREADY;
    logic [ADDR_W-1:0]   M_AXI_ARADDR;
    logic [2:0]          M_AXI_ARPROT;
    logic                M_AXI_ARVALID;
    logic                M_AXI_ARREADY;
    logic [DATA_W-1:0]   M_AXI_RDATA;
    logic [1:0]          M_AXI_RRESP;
    logic                M_AXI_RVALID;
    logic                M_AXI_RREADY;

    modport master (
        output M_AXI_AWADDR, M_AXI_AWPROT, M_AXI_AWVALID,
        input  M_AXI_AWREADY,
        output M_AXI_WDATA, M_AXI_WSTRB, M_AXI_WVALID,
        input  M_AXI_WREADY,
        input  M_AXI_BRESP, M_AXI_BVALID,
        output M_AXI_BREADY,
        output M_AXI_ARADDR, M_AXI_ARPROT, M_AXI_ARVALID,
        input  M_AXI_ARREADY,
        input  M_AXI_RDATA, M_AXI_RRESP, M_AXI_RVALID,
        output M_AXI_RREADY
    );

    modport slave (
        input  M_AXI_AWADDR, M_AXI_AWPROT, M_AXI_AWVALID,
        output M_AXI_AWREADY,
        input  M_AXI_WDATA, M_AXI_WSTRB, M_AXI_WVALID,
        output M_AXI_WREADY,
        output M_AXI_BRESP, M_AXI_BVALID,
        input  M_AXI_BREADY,
        input  M_AXI_ARADDR, M_AXI_ARPROT, M_AXI_ARVALID,
        output M_AXI_ARREADY,
        output M_AXI_RDATA, M_AXI_RRESP, M_AXI_RVALID,
        input  M_AXI_RREADY
    );
endinterface

// File: rtl/core_controller_axi_master.sv
// Single-outstanding AXI4-Lite initiator driven by a local register
// command port, with a response-phase timeout and late-response drain.
module core_controller_axi_master #(
    parameter int          C_M_AXI_DATA_WIDTH = 32,
    parameter int          C_M_AXI_ADDR_WIDTH = 16,
    parameter int unsigned TIMEOUT_CYCLES     = 1024
) (
    input  logic                          M_AXI_ACLK,
    input  logic                          M_AXI_ARSTN,
    input  logic                          CMD_VALID,
    output logic                          CMD_READY,
    input  logic                          CMD_WE,
    input  logic [C_M_AXI_ADDR_WIDTH-1:0] CMD_ADDR,
    input  logic [C_M_AXI_DATA_WIDTH-1:0] CMD_WDATA,
    output logic                          RSP_VALID,
    output logic [C_M_AXI_DATA_WIDTH-1:0] RSP_RDATA,
    output logic [1:0]                    RSP_RESP,
    output logic                          RSP_TIMEOUT,
    core_controller_axi_master_if.master  m_axi
);
    localparam int AW = C_M_AXI_ADDR_WIDTH;
    localparam int DW = C_M_AXI_DATA_WIDTH;
    localparam int CW = (TIMEOUT_CYCLES == 0) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CW-1:0] TO_LAST = CW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        IDLE,
        WR_REQ,
        WR_RESP,
        RD_REQ,
        RD_RESP,
        DRAIN
    } state_t;

    state_t         state_q, state_d;
    logic           cmd_ready_q, cmd_ready_d;
    logic           awvalid_q, awvalid_d;
    logic           wvalid_q, wvalid_d;
    logic           arvalid_q, arvalid_d;
    logic           bready_q, bready_d;
    logic           rready_q, rready_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [AW-1:0]  addr_q, addr_d;
    logic [DW-1:0]  wdata_q, wdata_d;
    logic           rsp_valid_q, rsp_valid_d;
    logic [DW-1:0]  rsp_rdata_q, rsp_rdata_d;
    logic [1:0]     rsp_resp_q, rsp_resp_d;
    logic           rsp_timeout_q, rsp_timeout_d;
    logic           rsp_hit;
    logic           to_hit;

    assign rsp_hit = (bready_q & m_axi.M_AXI_BVALID) |
                     (rready_q & m_axi.M_AXI_RVALID);
    assign to_hit  = (TIMEOUT_CYCLES != 0) && (cnt_q == TO_LAST);

    always_comb begin
        state_d       = state_q;
        awvalid_d     = awvalid_q;
        wvalid_d      = wvalid_q;
        arvalid_d     = arvalid_q;
        bready_d      = bready_q;
        rready_d      = rready_q;
        cnt_d         = cnt_q;
        addr_d        = addr_q;
        wdata_d       = wdata_q;
        rsp_valid_d   = 1'b0;
        rsp_rdata_d   = rsp_rdata_q;
        rsp_resp_d    = rsp_resp_q;
        rsp_timeout_d = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (CMD_VALID && cmd_ready_q) begin
                    addr_d  = CMD_ADDR & ~AW'(3);
                    wdata_d = CMD_WDATA;
                    if (CMD_WE) begin
                        state_d   = WR_REQ;
                        awvalid_d = 1'b1;
                        wvalid_d  = 1'b1;
                    end else begin
                        state_d   = RD_REQ;
                        arvalid_d = 1'b1;
                    end
                end
            end
            WR_REQ: begin
                awvalid_d = awvalid_q & ~m_axi.M_AXI_AWREADY;
                wvalid_d  = wvalid_q & ~m_axi.M_AXI_WREADY;
                if (!awvalid_d && !wvalid_d) begin
                    state_d  = WR_RESP;
                    bready_d = 1'b1;
                    cnt_d    = '0;
                end
            end
            RD_REQ: begin
                if (m_axi.M_AXI_ARREADY) begin
                    state_d   = RD_RESP;
                    arvalid_d = 1'b0;
                    rready_d  = 1'b1;
                    cnt_d     = '0;
                end
            end
            WR_RESP, RD_RESP: begin
                if (rsp_hit) begin
                    state_d     = IDLE;
                    bready_d    = 1'b0;
                    rready_d    = 1'b0;
                    rsp_valid_d = 1'b1;
                    rsp_rdata_d = rready_q ? m_axi.M_AXI_RDATA : '0;
                    rsp_resp_d  = rready_q ? m_axi.M_AXI_RRESP
                                           : m_axi.M_AXI_BRESP;
                end else if (TIMEOUT_CYCLES != 0) begin
                    cnt_d = cnt_q + CW'(1);
                    // Keep READY up in DRAIN so the late beat is swallowed
                    if (to_hit) begin
                        state_d       = DRAIN;
                        rsp_valid_d   = 1'b1;
                        rsp_timeout_d = 1'b1;
                        rsp_resp_d    = 2'b10;
                        rsp_rdata_d   = '0;
                    end
                end
            end
            DRAIN: begin
                if (rsp_hit) begin
                    state_d  = IDLE;
                    bready_d = 1'b0;
                    rready_d = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase
        cmd_ready_d = (state_d == IDLE);
    end

    always_ff @(posedge M_AXI_ACLK or negedge M_AXI_ARSTN) begin
        if (!M_AXI_ARSTN) begin
            state_q       <= IDLE;
            cmd_ready_q   <= 1'b0;
            awvalid_q     <= 1'b0;
            wvalid_q      <= 1'b0;
            arvalid_q     <= 1'b0;
            bready_q      <= 1'b0;
            rready_q      <= 1'b0;
            cnt_q         <= '0;
            addr_q        <= '0;
            wdata_q       <= '0;
            rsp_valid_q   <= 1'b0;
            rsp_rdata_q   <= '0;
            rsp_resp_q    <= 2'b00;
            rsp_timeout_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            cmd_ready_q   <= cmd_ready_d;
            awvalid_q     <= awvalid_d;
            wvalid_q      <= wvalid_d;
            arvalid_q     <= arvalid_d;
            bready_q      <= bready_d;
            rready_q      <= rready_d;
            cnt_q         <= cnt_d;
            addr_q        <= addr_d;
            wdata_q       <= wdata_d;
            rsp_valid_q   <= rsp_valid_d;
            rsp_rdata_q   <= rsp_rdata_d;
            rsp_resp_q    <= rsp_resp_d;
            rsp_timeout_q <= rsp_timeout_d;
        end
    end

    assign CMD_READY   = cmd_ready_q;
    assign RSP_VALID   = rsp_valid_q;
    assign RSP_RDATA   = rsp_rdata_q;
    assign RSP_RESP    = rsp_resp_q;
    assign RSP_TIMEOUT = rsp_timeout_q;

    assign m_axi.M_AXI_AWADDR  = addr_q;
    assign m_axi.M_AXI_AWPROT  = 3'b000;
    assign m_axi.M_AXI_AWVALID = awvalid_q;
    assign m_axi.M_AXI_WDATA   = wdata_q;
    assign m_axi.M_AXI_WSTRB   = '1;
    assign m_axi.M_AXI_WVALID  = wvalid_q;
    assign m_axi.M_AXI_BREADY  = bready_q;
    assign m_axi.M_AXI_ARADDR  = addr_q;
    assign m_axi.M_AXI_ARPROT  = 3'b000;
    assign m_axi.M_AXI_ARVALID = arvalid_q;
    assign m_axi.M_AXI_RREADY  = rready_q;
endmodule

// File: tb/tb_core_controller_axi_master.sv
// Directed bench for core_controller_axi_master: zero-wait and stalled
// writes/reads, error responses, timeout drain and mid-transaction reset.
module tb_core_controller_axi_master;
    logic        clk;
    logic        rst_n;
    logic        cmd_valid;
    logic        cmd_ready;
    logic        cmd_we;
    logic [15:0] cmd_addr;
    logic [31:0] cmd_wdata;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic [1:0]  rsp_resp;
    logic        rsp_timeout;

    int total;
    int bad;
    logic acc;

    core_controller_axi_master_if #(.ADDR_W(16), .DATA_W(32)) axi ();

    core_controller_axi_master #(
        .C_M_AXI_DATA_WIDTH(32),
        .C_M_AXI_ADDR_WIDTH(16),
        .TIMEOUT_CYCLES(8)
    ) dut (
        .M_AXI_ACLK (clk),
        .M_AXI_ARSTN(rst_n),
        .CMD_VALID  (cmd_valid),
        .CMD_READY  (cmd_ready),
        .CMD_WE     (cmd_we),
        .CMD_ADDR   (cmd_addr),
        .CMD_WDATA  (cmd_wdata),
        .RSP_VALID  (rsp_valid),
        .RSP_RDATA  (rsp_rdata),
        .RSP_RESP   (rsp_resp),
        .RSP_TIMEOUT(rsp_timeout),
        .m_axi      (axi)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic we, input logic [15:0] a,
                         input logic [31:0] d);
        cmd_valid = 1'b1;
        cmd_we    = we;
        cmd_addr  = a;
        cmd_wdata = d;
    endtask

    function automatic logic [4:0] vr();
        return {axi.M_AXI_AWVALID, axi.M_AXI_WVALID, axi.M_AXI_ARVALID,
                axi.M_AXI_BREADY, axi.M_AXI_RREADY};
    endfunction

    initial begin
        total = 0;
        bad   = 0;
        rst_n = 1'b0;
        cmd_valid = 1'b0;
        cmd_we    = 1'b0;
        cmd_addr  = '0;
        cmd_wdata = '0;
        axi.M_AXI_AWREADY = 1'b0;
        axi.M_AXI_WREADY  = 1'b0;
        axi.M_AXI_BVALID  = 1'b0;
        axi.M_AXI_BRESP   = 2'b00;
        axi.M_AXI_ARREADY = 1'b0;
        axi.M_AXI_RVALID  = 1'b0;
        axi.M_AXI_RDATA   = '0;
        axi.M_AXI_RRESP   = 2'b00;

        repeat (2) @(posedge clk);
        #1;
        check("rst_valids", 32'(vr()), 0);
        check("rst_cmd_ready", 32'(cmd_ready), 0);
        check("rst_rsp", {rsp_valid, rsp_timeout, rsp_resp}, 0);
        check("rst_rdata", rsp_rdata, 0);
        check("rst_addr", {axi.M_AXI_AWADDR, axi.M_AXI_ARADDR}, 0);
        check("rst_wdata", axi.M_AXI_WDATA, 0);
        #4 rst_n = 1'b1;
        tick();
        check("ready_after_rst", 32'(cmd_ready), 1);

        // zero-wait write, BVALID held early to show it is ignored
        axi.M_AXI_AWREADY = 1'b1;
        axi.M_AXI_WREADY  = 1'b1;
        axi.M_AXI_BVALID  = 1'b1;
        axi.M_AXI_BRESP   = 2'b00;
        issue(1'b1, 16'h0004, 32'h0000_0001);
        tick();
        cmd_valid = 1'b0;
        check("t1_c1_vr", 32'(vr()), 32'b11000);
        check("t1_awaddr", 32'(axi.M_AXI_AWADDR), 32'h4);
        check("t1_wdata", axi.M_AXI_WDATA, 32'h1);
        check("t1_const", {axi.M_AXI_AWPROT, axi.M_AXI_ARPROT,
                           axi.M_AXI_WSTRB}, 10'h00F);
        check("t1_cmd_ready_busy", 32'(cmd_ready), 0);
        tick();
        check("t1_c2_vr", 32'(vr()), 32'b00010);
        check("t1_c2_rsp", 32'(rsp_valid), 0);
        tick();
        check("t1_rsp", {rsp_valid, rsp_timeout, rsp_resp}, 4'b1000);
        check("t1_rdata", rsp_rdata, 0);
        check("t1_vr_idle", 32'(vr()), 0);
        check("t1_cmd_ready", 32'(cmd_ready), 1);

        // back-to-back write, WREADY late, BRESP=SLVERR
        axi.M_AXI_WREADY = 1'b0;
        axi.M_AXI_BVALID = 1'b0;
        issue(1'b1, 16'h0008, 32'hA5A5_0008);
        tick();
        cmd_valid = 1'b0;
        check("t2_c1_vr", 32'(vr()), 32'b11000);
        check("t2_c1_rsp", 32'(rsp_valid), 0);
        check("t2_awaddr", 32'(axi.M_AXI_AWADDR), 32'h8);
        tick();
        check("t2_c2_vr", 32'(vr()), 32'b01000);
        tick();
        check("t2_c3_vr", 32'(vr()), 32'b01000);
        tick();
        check("t2_c4_vr", 32'(vr()), 32'b01000);
        check("t2_wdata", axi.M_AXI_WDATA, 32'hA5A5_0008);
        axi.M_AXI_WREADY = 1'b1;
        tick();
        check("t2_c5_vr", 32'(vr()), 32'b00010);
        axi.M_AXI_BVALID = 1'b1;
        axi.M_AXI_BRESP  = 2'b10;
        tick();
        axi.M_AXI_BVALID = 1'b0;
        check("t2_rsp", {rsp_valid, rsp_timeout, rsp_resp}, 4'b1010);
        check("t2_rdata", rsp_rdata, 0);

        // read from unaligned address, ARREADY late
        axi.M_AXI_ARREADY = 1'b0;
        issue(1'b0, 16'h000E, 32'hFFFF_FFFF);
        tick();
        cmd_valid = 1'b0;
        check("t3_c1_vr", 32'(vr()), 32'b00100);
        check("t3_araddr", 32'(axi.M_AXI_ARADDR), 32'hC);
        tick();
        check("t3_c2_vr", 32'(vr()), 32'b00100);
        tick();
        check("t3_c3_vr", 32'(vr()), 32'b00100);
        axi.M_AXI_ARREADY = 1'b1;
        tick();
        axi.M_AXI_ARREADY = 1'b0;
        check("t3_c4_vr", 32'(vr()), 32'b00001);
        check("t3_c4_rsp", 32'(rsp_valid), 0);
        axi.M_AXI_RVALID = 1'b1;
        axi.M_AXI_RDATA  = 32'h0000_005A;
        axi.M_AXI_RRESP  = 2'b00;
        tick();
        axi.M_AXI_RVALID = 1'b0;
        check("t3_rsp", {rsp_valid, rsp_timeout, rsp_resp}, 4'b1000);
        check("t3_rdata", rsp_rdata, 32'h5A);
        check("t3_vr_idle", 32'(vr()), 0);

        // zero-wait read with DECERR
        axi.M_AXI_ARREADY = 1'b1;
        axi.M_AXI_RVALID  = 1'b1;
        axi.M_AXI_RDATA   = 32'hDEAD_BEEF;
        axi.M_AXI_RRESP   = 2'b11;
        issue(1'b0, 16'h0020, 32'h0);
        tick();
        cmd_valid = 1'b0;
        check("t4_c1_vr", 32'(vr()), 32'b00100);
        tick();
        check("t4_c2", {vr(), rsp_valid}, 6'b000010);
        tick();
        axi.M_AXI_RVALID = 1'b0;
        check("t4_rsp", {rsp_valid, rsp_timeout, rsp_resp}, 4'b1011);
        check("t4_rdata", rsp_rdata, 32'hDEAD_BEEF);

        // read timeout after 8 RD_RESP cycles, then drain late beat
        issue(1'b0, 16'h0030, 32'h0);
        tick();
        cmd_valid = 1'b0;
        tick();
        check("t5_c2_vr", 32'(vr()), 32'b00001);
        acc = 1'b0;
        repeat (7) begin
            tick();
            acc = acc | rsp_valid;
        end
        check("t5_no_early_rsp", 32'(acc), 0);
        tick();
        check("t5_to_rsp", {rsp_valid, rsp_timeout, rsp_resp}, 4'b1110);
        check("t5_to_rdata", rsp_rdata, 0);
        check("t5_to_cmd_ready", 32'(cmd_ready), 0);
        check("t5_to_rready", 32'(axi.M_AXI_RREADY), 1);
        acc = 1'b0;
        repeat (10) begin
            tick();
            acc = acc | cmd_ready | rsp_valid | ~axi.M_AXI_RREADY;
        end
        check("t5_drain_hold", 32'(acc), 0);
        axi.M_AXI_RVALID = 1'b1;
        axi.M_AXI_RDATA  = 32'h0000_1234;
        axi.M_AXI_RRESP  = 2'b00;
        tick();
        axi.M_AXI_RVALID = 1'b0;
        check("t5_after_drain", {cmd_ready, rsp_valid, rsp_timeout,
                                 axi.M_AXI_RREADY}, 4'b1000);
        check("t5_discard_rdata", rsp_rdata, 0);

        // async reset while in WR_REQ
        axi.M_AXI_AWREADY = 1'b0;
        axi.M_AXI_WREADY  = 1'b0;
        axi.M_AXI_BVALID  = 1'b0;
        issue(1'b1, 16'h0040, 32'h0000_0077);
        tick();
        cmd_valid = 1'b0;
        check("t6_c1_vr", 32'(vr()), 32'b11000);
        #2 rst_n = 1'b0;
        #1;
        check("t6_async_vr", 32'(vr()), 0);
        check("t6_async_rsp", {rsp_valid, cmd_ready}, 0);
        #3 rst_n = 1'b1;
        tick();
        check("t6_rel", {cmd_ready, rsp_valid, vr()}, 7'b1000000);
        axi.M_AXI_AWREADY = 1'b1;
        axi.M_AXI_WREADY  = 1'b1;
        axi.M_AXI_BVALID  = 1'b1;
        axi.M_AXI_BRESP   = 2'b00;
        issue(1'b1, 16'h0042, 32'h0000_0055);
        tick();
        cmd_valid = 1'b0;
        check("t6_awaddr", 32'(axi.M_AXI_AWADDR), 32'h40);
        check("t6_wdata", axi.M_AXI_WDATA, 32'h55);
        tick();
        check("t6_c2", {vr(), rsp_valid}, 6'b000100);
        tick();
        check("t6_rsp", {rsp_valid, rsp_timeout, rsp_resp}, 4'b1000);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
